// File: rtl/approx_chk_pkg.sv
// Shared types and helpers for the approximate-multiplier sweep checker.
//   state_e  : checker FSM states
//   abs_diff : unsigned |a - b| on a 32-bit carrier
//   sat_inc  : increment that sticks at the all-ones value of a w-bit field
package approx_chk_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSweep,
    StDrain,
    StDone
  } state_e;

  localparam int unsigned FnW = 32;

  function automatic logic [FnW-1:0] abs_diff(input logic [FnW-1:0] a,
                                              input logic [FnW-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Callers zero-extend a w-bit field (w <= 32) and take the low w bits back.
  function automatic logic [FnW-1:0] sat_inc(input logic [FnW-1:0] v, input int unsigned w);
    logic [FnW-1:0] max_v;
    max_v = (w >= FnW) ? '1 : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/approx_err_acc.sv
// Second pipeline stage of the sweep checker: exact product, absolute error against the
// approximate product, and saturating error statistics.
// Optional feature macro: ERR_HIST_EN adds err_hist_o, one saturating bin per error value.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   clr_i          clear all statistics (start of a new sweep)
//   valid_i        S1 holds a sample to account this cycle
//   op_a_i/op_b_i  operands registered in S1
//   approx_i       approximate product registered in S1
//   sample_cnt_o   samples accounted
//   viol_cnt_o     samples with error > ET
//   max_err_o      largest error seen
//   err_sum_o      sum of errors
//   err_hist_o     (ERR_HIST_EN only) flattened bins, bin i at [i*CNT_W +: CNT_W]
module approx_err_acc
  import approx_chk_pkg::*;
#(
  parameter int unsigned OPW   = 2,
  parameter int unsigned ET    = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr_i,
  input  logic                        valid_i,
  input  logic [OPW-1:0]              op_a_i,
  input  logic [OPW-1:0]              op_b_i,
  input  logic [2*OPW-1:0]            approx_i,
  output logic [CNT_W-1:0]            sample_cnt_o,
  output logic [CNT_W-1:0]            viol_cnt_o,
  output logic [2*OPW-1:0]            max_err_o,
  output logic [CNT_W+2*OPW-1:0]      err_sum_o
`ifdef ERR_HIST_EN
  ,
  output logic [(2**(2*OPW))*CNT_W-1:0] err_hist_o
`endif
);

  localparam int unsigned PW    = 2 * OPW;
  localparam int unsigned SW    = CNT_W + PW;
  localparam int unsigned NBins = 2 ** PW;

  logic [PW-1:0]    exact;
  logic [PW-1:0]    err;
  logic [FnW-1:0]   diff_w;
  logic             viol;
  logic [FnW-1:0]   sample_inc;
  logic [FnW-1:0]   viol_inc;
  logic [SW:0]      sum_ext;

  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0] viol_cnt_q, viol_cnt_d;
  logic [PW-1:0]    max_err_q, max_err_d;
  logic [SW-1:0]    err_sum_q, err_sum_d;

  // OPW x OPW product always fits in PW bits.
  always_comb begin
    exact  = PW'(op_a_i) * PW'(op_b_i);
    diff_w = abs_diff(FnW'(exact), FnW'(approx_i));
    err    = diff_w[PW-1:0];
    viol   = diff_w > ET;
  end

  always_comb begin
    sample_cnt_d = sample_cnt_q;
    viol_cnt_d   = viol_cnt_q;
    max_err_d    = max_err_q;
    err_sum_d    = err_sum_q;
    sample_inc   = sat_inc(FnW'(sample_cnt_q), CNT_W);
    viol_inc     = sat_inc(FnW'(viol_cnt_q), CNT_W);
    // Extra top bit catches the carry so the sum can stick at all-ones.
    sum_ext      = {1'b0, err_sum_q} + (SW + 1)'(err);
    if (clr_i) begin
      sample_cnt_d = '0;
      viol_cnt_d   = '0;
      max_err_d    = '0;
      err_sum_d    = '0;
    end else if (valid_i) begin
      sample_cnt_d = sample_inc[CNT_W-1:0];
      if (viol) viol_cnt_d = viol_inc[CNT_W-1:0];
      if (err > max_err_q) max_err_d = err;
      err_sum_d = sum_ext[SW] ? '1 : sum_ext[SW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample_cnt_q <= '0;
      viol_cnt_q   <= '0;
      max_err_q    <= '0;
      err_sum_q    <= '0;
    end else begin
      sample_cnt_q <= sample_cnt_d;
      viol_cnt_q   <= viol_cnt_d;
      max_err_q    <= max_err_d;
      err_sum_q    <= err_sum_d;
    end
  end

  assign sample_cnt_o = sample_cnt_q;
  assign viol_cnt_o   = viol_cnt_q;
  assign max_err_o    = max_err_q;
  assign err_sum_o    = err_sum_q;

`ifdef ERR_HIST_EN
  logic [CNT_W-1:0] hist_q [NBins];
  logic [CNT_W-1:0] hist_d [NBins];
  logic [FnW-1:0]   bin_inc;

  always_comb begin
    hist_d  = hist_q;
    bin_inc = sat_inc(FnW'(hist_q[err]), CNT_W);
    if (clr_i) begin
      for (int i = 0; i < NBins; i++) hist_d[i] = '0;
    end else if (valid_i) begin
      hist_d[err] = bin_inc[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NBins; i++) hist_q[i] <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

  always_comb begin
    err_hist_o = '0;
    for (int i = 0; i < NBins; i++) err_hist_o[i*CNT_W +: CNT_W] = hist_q[i];
  end
`endif

endmodule

// File: rtl/approx_mul_sweep_checker.sv
// Sweep-and-check harness around a combinational approximate multiplier. Drives every operand
// pair out on op_a/op_b, samples the multiplier's answer in the same cycle (S1), and hands it
// to approx_err_acc (S2) for error statistics. pass reports a clean sweep in DONE.
// Optional feature macro: ERR_HIST_EN adds the err_hist output (per-error-value bins).
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start                 begin a sweep (honoured in IDLE/DONE only)
//   stall                 hold the sweep index this cycle, injecting a bubble
//   op_a, op_b            operands to the multiplier (registered)
//   approx_p              multiplier result
//   busy                  high in SWEEP and DRAIN
//   done                  one-cycle pulse on entering DONE
//   pass                  no violations; valid in DONE
//   sample_cnt, viol_cnt  saturating sample / violation counters
//   max_err, err_sum      largest error and saturating sum of errors
//   err_hist              (ERR_HIST_EN only) flattened error histogram
module approx_mul_sweep_checker
  import approx_chk_pkg::*;
#(
  parameter int unsigned OPW   = 2,
  parameter int unsigned ET    = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        stall,
  output logic [OPW-1:0]              op_a,
  output logic [OPW-1:0]              op_b,
  input  logic [2*OPW-1:0]            approx_p,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic [CNT_W-1:0]            sample_cnt,
  output logic [CNT_W-1:0]            viol_cnt,
  output logic [2*OPW-1:0]            max_err,
  output logic [CNT_W+2*OPW-1:0]      err_sum
`ifdef ERR_HIST_EN
  ,
  output logic [(2**(2*OPW))*CNT_W-1:0] err_hist
`endif
);

  localparam int unsigned PW = 2 * OPW;

  state_e         state_q, state_d;
  logic [PW-1:0]  idx_q, idx_d;
  logic           drain_q, drain_d;
  logic           done_q, done_d;
  logic           pass_q, pass_d;
  logic           clr_stats;

  logic           s1_valid_q, s1_valid_d;
  logic [OPW-1:0] s1_a_q;
  logic [OPW-1:0] s1_b_q;
  logic [PW-1:0]  s1_p_q;

  // Operands come straight off the index register, so they are registered outputs.
  assign op_a = idx_q[OPW-1:0];
  assign op_b = idx_q[PW-1:OPW];

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    drain_d    = drain_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    clr_stats  = 1'b0;
    s1_valid_d = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d   = StSweep;
          idx_d     = '0;
          pass_d    = 1'b0;
          clr_stats = 1'b1;
        end
      end
      StSweep: begin
        s1_valid_d = !stall;
        if (!stall) begin
          if (idx_q == '1) begin
            // Last pair is being issued; index parks at all-ones.
            state_d = StDrain;
            drain_d = 1'b0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StDrain: begin
        // Two cycles let the last sample clear S1 and S2 before pass is judged.
        if (drain_q) begin
          state_d = StDone;
          done_d  = 1'b1;
          pass_d  = (viol_cnt == '0);
        end else begin
          drain_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      drain_q    <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_p_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      drain_q    <= drain_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= op_a;
      s1_b_q     <= op_b;
      s1_p_q     <= approx_p;
    end
  end

  assign busy = (state_q == StSweep) || (state_q == StDrain);
  assign done = done_q;
  assign pass = pass_q;

  approx_err_acc #(
    .OPW  (OPW),
    .ET   (ET),
    .CNT_W(CNT_W)
  ) u_err_acc (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (clr_stats),
    .valid_i     (s1_valid_q),
    .op_a_i      (s1_a_q),
    .op_b_i      (s1_b_q),
    .approx_i    (s1_p_q),
    .sample_cnt_o(sample_cnt),
    .viol_cnt_o  (viol_cnt),
    .max_err_o   (max_err),
    .err_sum_o   (err_sum)
`ifdef ERR_HIST_EN
    ,
    .err_hist_o  (err_hist)
`endif
  );

endmodule

// File: tb/tb_approx_mul_sweep_checker.sv
// Directed bench for approx_mul_sweep_checker with an in-bench 2x2-bit multiplier model.
module tb_approx_mul_sweep_checker;

  localparam int unsigned OPW   = 2;
  localparam int unsigned PW    = 4;
  localparam int unsigned CNT_W = 16;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  start;
  logic                  stall;
  logic [OPW-1:0]        op_a;
  logic [OPW-1:0]        op_b;
  logic [PW-1:0]         approx_p;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic [CNT_W-1:0]      sample_cnt;
  logic [CNT_W-1:0]      viol_cnt;
  logic [PW-1:0]         max_err;
  logic [CNT_W+PW-1:0]   err_sum;
`ifdef ERR_HIST_EN
  logic [(2**PW)*CNT_W-1:0] err_hist;
`endif

  int mode;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Multiplier model: 0 exact, 1 gives 3*3=8, 2 gives 3*3=0 and 1*1=2.
  always_comb begin
    approx_p = {2'b00, op_a} * {2'b00, op_b};
    if (mode == 1 && op_a == 2'd3 && op_b == 2'd3) approx_p = 4'd8;
    if (mode == 2 && op_a == 2'd3 && op_b == 2'd3) approx_p = 4'd0;
    if (mode == 2 && op_a == 2'd1 && op_b == 2'd1) approx_p = 4'd2;
  end

  approx_mul_sweep_checker #(
    .OPW  (OPW),
    .ET   (1),
    .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stall     (stall),
    .op_a      (op_a),
    .op_b      (op_b),
    .approx_p  (approx_p),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .sample_cnt(sample_cnt),
    .viol_cnt  (viol_cnt),
    .max_err   (max_err),
    .err_sum   (err_sum)
`ifdef ERR_HIST_EN
    ,
    .err_hist  (err_hist)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_stats(input string tag, input int sc, input int vc, input int me,
                             input int es, input int ps);
    check({tag, "_samples"}, 64'(sample_cnt), 64'(sc));
    check({tag, "_viol"},    64'(viol_cnt),   64'(vc));
    check({tag, "_max_err"}, 64'(max_err),    64'(me));
    check({tag, "_err_sum"}, 64'(err_sum),    64'(es));
    check({tag, "_pass"},    64'(pass),       64'(ps));
    check({tag, "_busy"},    64'(busy),       64'(0));
  endtask

  // Called at a negedge. Cycle n is the one following the n-th rising edge after start is
  // raised; stall_mask[n] / start_at select what is driven into edge n+1.
  task automatic run_sweep(input logic [63:0] stall_mask, input int start_at,
                           output int done_cyc);
    done_cyc = -1;
    start    = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      @(negedge clk);
      start = (n == start_at);
      stall = (n < 64) ? stall_mask[n] : 1'b0;
      if (done) begin
        done_cyc = n;
        check("done_not_busy", 64'(busy), 64'(0));
        break;
      end
    end
    start = 1'b0;
    stall = 1'b0;
  endtask

  int dc;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    mode  = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_pass", 64'(pass), 64'(0));
    check("rst_samples", 64'(sample_cnt), 64'(0));
    check("rst_err_sum", 64'(err_sum), 64'(0));
    check("rst_op", 64'({op_b, op_a}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // T1: exact multiplier
    run_sweep(64'd0, -1, dc);
    check("t1_done_cyc", 64'(dc), 64'(19));
    check_stats("t1", 16, 0, 0, 0, 1);
    repeat (3) @(negedge clk);
    check("t1_done_low", 64'(done), 64'(0));
    check("t1_hold_samples", 64'(sample_cnt), 64'(16));

    // T2: 3*3 -> 8, error 1 is within threshold
    mode = 1;
    run_sweep(64'd0, -1, dc);
    check("t2_done_cyc", 64'(dc), 64'(19));
    check_stats("t2", 16, 0, 1, 1, 1);

    // T3: 3*3 -> 0 (err 9), 1*1 -> 2 (err 1)
    mode = 2;
    run_sweep(64'd0, -1, dc);
    check("t3_done_cyc", 64'(dc), 64'(19));
    check_stats("t3", 16, 1, 9, 10, 0);

    // T4: five stall cycles during SWEEP
    mode = 0;
    run_sweep((64'd1 << 3) | (64'd1 << 4) | (64'd1 << 8) | (64'd1 << 11) | (64'd1 << 12),
              -1, dc);
    check("t4_done_cyc", 64'(dc), 64'(24));
    check_stats("t4", 16, 0, 0, 0, 1);

    // T5: reset while idx=7 is presented
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("t5_op_a", 64'(op_a), 64'(3));
    check("t5_op_b", 64'(op_b), 64'(1));
    check("t5_mid_samples", 64'(sample_cnt), 64'(6));
    check("t5_mid_pass", 64'(pass), 64'(0));
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t5_rst_busy", 64'(busy), 64'(0));
    check("t5_rst_samples", 64'(sample_cnt), 64'(0));
    check("t5_rst_op", 64'({op_b, op_a}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    run_sweep(64'd0, -1, dc);
    check("t5_done_cyc", 64'(dc), 64'(19));
    check_stats("t5", 16, 0, 0, 0, 1);

    // T6: T3 model, start raised while in DRAIN must be ignored
    mode = 2;
    run_sweep(64'd0, 17, dc);
    check("t6_done_cyc", 64'(dc), 64'(19));
    check_stats("t6", 16, 1, 9, 10, 0);
`ifdef ERR_HIST_EN
    for (int i = 0; i < 16; i++) begin
      int exp_bin;
      exp_bin = (i == 0) ? 14 : ((i == 1 || i == 9) ? 1 : 0);
      check($sformatf("t6_bin%0d", i), 64'(err_hist[i*CNT_W +: CNT_W]), 64'(exp_bin));
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
